// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    // Arbiter FSM encoding; the raw bit is exported as diag_state.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Widest requester vector the pick helper handles.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_REQ_W = 5;

    // Round-robin pick: the first requester at or after ptr, wrapping
    // modulo n_req. Returns ptr when nobody requests (caller gates on |req).
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        n_req,
        input int unsigned        ptr
    );
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n_req) begin
                idx = ptr + k;
                if (idx >= n_req) begin
                    idx = idx - n_req;
                end
                if (!found && req[idx[MAX_REQ_W-1:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fifo_credit_counter.sv
// Local image of FIFO occupancy. A write is counted the cycle it is
// presented to the FIFO; a read only once the FIFO actually accepted it
// (not empty), so the credit check is always conservative.
module fifo_credit_counter
    import fifo_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_write,
    input  logic             fifo_full,
    input  logic             fifo_read,
    input  logic             fifo_empty,
    output logic [OCC_W-1:0] occ,
    output logic             credit_ok,
    output logic             err_overflow
);

    logic read_lands;

    assign read_lands = fifo_read && !fifo_empty;

    // Room for one more word even counting the write already in flight.
    assign credit_ok = (32'(occ) + 32'(fifo_write)) < 32'(DEPTH);

    // Occupancy tracks accepted writes minus accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({fifo_write, read_lands})
                2'b10: begin
                    if (32'(occ) < 32'(DEPTH)) begin
                        occ <= occ + 1'b1;
                    end
                end
                2'b01: begin
                    if (occ != '0) begin
                        occ <= occ - 1'b1;
                    end
                end
                default: occ <= occ;
            endcase
        end
    end

    // Sticky flag for a write strobe landing on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow <= 1'b0;
        end else if (fifo_write && fifo_full) begin
            err_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with a per-owner burst limit in front of a
// shared FIFO. Grants are combinational; the FIFO write port is driven
// one cycle later from registers.
//
// Handshake: req[i] is a level held by producer i while it has a word on
// req_data slice i. gnt[i] high in a cycle means that word is consumed at
// the coming clock edge; the producer may then drop req or present its
// next word. gnt is one-hot or zero and never asserted without credit.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int MAX_BURST  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              gnt,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic                          fifo_read,
    output logic [$clog2(DEPTH+1)-1:0]    diag_occ,
    output logic [$clog2(N_REQ)-1:0]      diag_owner,
    output logic                          diag_state,
    output logic                          err_overflow
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int OWN_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t              state;
    logic [OWN_W-1:0]        owner;
    logic [OWN_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]        burst_cnt;

    logic                    credit_ok;
    logic [OCC_W-1:0]        occ;

    logic                    cont_burst;
    logic                    burst_end;
    logic [OWN_W-1:0]        owner_inc;
    logic [OWN_W-1:0]        arb_ptr;
    logic [OWN_W-1:0]        pick;
    logic [OWN_W-1:0]        pick_inc;
    logic [MAX_REQ-1:0]      req_ext;
    logic                    new_grant;
    logic                    burst_grant;
    logic                    grant_any;
    logic [OWN_W-1:0]        gnt_idx;
    logic [N_REQ-1:0]        gnt_vec;
    logic [DATA_WIDTH-1:0]   sel_data;

    fifo_credit_counter #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .fifo_write   (fifo_write),
        .fifo_full    (fifo_full),
        .fifo_read    (fifo_read),
        .fifo_empty   (fifo_empty),
        .occ          (occ),
        .credit_ok    (credit_ok),
        .err_overflow (err_overflow)
    );

    assign req_ext = MAX_REQ'(req);

    // Burst bookkeeping: does the current owner keep the port, and where
    // does round-robin start if it does not (old owner goes last).
    always_comb begin
        owner_inc  = (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        cont_burst = (state == ARB_BURST) && req[owner] &&
                     (burst_cnt < CNT_W'(MAX_BURST));
        burst_end  = (state == ARB_BURST) && !cont_burst;
        arb_ptr    = burst_end ? owner_inc : rr_ptr;
    end

    // Round-robin candidate for a fresh burst, and the pointer after it.
    always_comb begin
        pick     = OWN_W'(rr_pick(req_ext, 32'(N_REQ), 32'(arb_ptr)));
        pick_inc = (pick == OWN_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
    end

    // Grant decision: continue the burst, or start a new one with no bubble.
    always_comb begin
        new_grant   = !rst && !cont_burst && credit_ok && (|req);
        burst_grant = !rst && cont_burst && credit_ok;
        grant_any   = new_grant || burst_grant;
        gnt_idx     = cont_burst ? owner : pick;
        gnt_vec     = '0;
        if (grant_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign gnt = gnt_vec;

    // Word of the granted producer, steered into the write register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_vec[i]) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbiter FSM plus the registered FIFO write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            fifo_write <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            fifo_write <= grant_any;
            if (grant_any) begin
                fifo_wdata <= sel_data;
            end

            if (cont_burst) begin
                // Owner still requesting under the limit; a credit stall
                // holds the burst without ending it.
                if (credit_ok) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                if (burst_end) begin
                    rr_ptr    <= owner_inc;
                    state     <= ARB_IDLE;
                    burst_cnt <= '0;
                end
                if (new_grant) begin
                    owner     <= pick;
                    burst_cnt <= CNT_W'(1);
                    if (MAX_BURST == 1) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= pick_inc;
                    end else begin
                        state  <= ARB_BURST;
                    end
                end
            end
        end
    end

    assign diag_occ   = occ;
    assign diag_owner = owner;
    assign diag_state = (state == ARB_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a queue-based
// FIFO and a rule-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 4;
  localparam int MAX_BURST  = 2;
  localparam int OCC_W      = $clog2(DEPTH + 1);
  localparam int OWN_W      = $clog2(N_REQ);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            gnt;
  logic                        fifo_write;
  logic [DATA_WIDTH-1:0]       fifo_wdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_read;
  logic [OCC_W-1:0]            diag_occ;
  logic [OWN_W-1:0]            diag_owner;
  logic                        diag_state;
  logic                        err_overflow;

  fifo_wr_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_write   (fifo_write),
    .fifo_wdata   (fifo_wdata),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .diag_occ     (diag_occ),
    .diag_owner   (diag_owner),
    .diag_state   (diag_state),
    .err_overflow (err_overflow)
  );

  // ---------------- FIFO model ----------------
  logic [DATA_WIDTH-1:0] fifo_q[$];
  int fifo_cnt = 0;
  assign fifo_full  = (fifo_cnt == DEPTH);
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
    end else begin
      if (fifo_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (fifo_write && fifo_q.size() < DEPTH) fifo_q.push_back(fifo_wdata);
    end
    fifo_cnt <= fifo_q.size();
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] prod_q[N_REQ][$];
  int gnt_log[$];
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // arbitration model
  int m_ptr = 0, m_owner = 0, m_cnt = 0;
  bit m_busy = 1'b0, m_inflight = 1'b0;

  int ord_all[12]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
  int ord_drop[4]  = '{0, 2, 2, 2};
  int ord_stall[8] = '{0, 1, 1, 1, -1, -1, 1, -1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (fifo_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(fifo_wdata), 32'hFFFF_FFFF);
        end else begin
          check("wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
        end
      end
      check("diag_occ", 32'(diag_occ), 32'(fifo_q.size()));
      check("err_overflow", 32'(err_overflow), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req();
    logic [N_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (prod_q[i].size() != 0) begin
        r[i] = 1'b1;
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = prod_q[i][0];
      end
    end
    req = r;
  endtask

  task automatic step(input bit rd);
    int exp_idx;
    int act_idx;
    bit credit;
    logic [N_REQ-1:0] exp_gnt;
    @(negedge clk);
    fifo_read = rd;
    drive_req();
    #1;
    credit  = (fifo_q.size() + int'(m_inflight)) < DEPTH;
    exp_idx = -1;
    if (m_busy && req[m_owner] && m_cnt < MAX_BURST) begin
      if (credit) begin
        exp_idx = m_owner;
        m_cnt++;
      end
    end else begin
      if (m_busy) begin
        m_ptr  = (m_owner + 1) % N_REQ;
        m_busy = 1'b0;
      end
      if (credit && req != '0) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (exp_idx < 0 && ((req >> ((m_ptr + k) % N_REQ)) & 1) != 0)
            exp_idx = (m_ptr + k) % N_REQ;
        end
        m_owner = exp_idx;
        m_cnt   = 1;
        m_busy  = (MAX_BURST > 1);
        if (MAX_BURST == 1) m_ptr = (exp_idx + 1) % N_REQ;
      end
    end
    exp_gnt = (exp_idx >= 0) ? (N_REQ'(1) << exp_idx) : '0;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    act_idx = -1;
    for (int i = N_REQ - 1; i >= 0; i--) if (gnt[i]) act_idx = i;
    gnt_log.push_back(act_idx);
    if (exp_idx >= 0) begin
      exp_q.push_back(prod_q[exp_idx].pop_front());
      m_inflight = 1'b1;
    end else begin
      m_inflight = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo_read = 1'b0;
    drive_req();
    #1;
    check("gnt_in_reset", 32'(gnt), 32'd0);
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_busy = 1'b0; m_inflight = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_diag_occ", 32'(diag_occ), 32'd0);
    check("rst_diag_state", 32'(diag_state), 32'd0);
    check("rst_diag_owner", 32'(diag_owner), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_fifo_wdata", 32'(fifo_wdata), 32'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      done = 1'b1;
      for (int i = 0; i < N_REQ; i++) if (prod_q[i].size() != 0) done = 1'b0;
      if (fifo_q.size() != 0 || m_inflight) done = 1'b0;
      if (!done) step(1'b1);
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req = '0;
    req_data = '0;
    fifo_read = 1'b0;
    do_reset();
    mon_en = 1'b1;

    // idle: no requests, no grant
    step(1'b0);
    step(1'b0);

    // single producer fills the FIFO with 1..4, then stalls on full
    for (int v = 1; v <= 5; v++) prod_q[0].push_back(DATA_WIDTH'(v));
    for (int c = 0; c < 8; c++) step(1'b0);
    check("fill_full", 32'(fifo_full), 32'd1);
    check("fill_occ", 32'(diag_occ), 32'(DEPTH));
    drain();

    // all requesting, consumer reads every cycle
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < N_REQ; i++)
      for (int v = 0; v < 6; v++) prod_q[i].push_back(DATA_WIDTH'($urandom_range(0, 255)));
    for (int c = 0; c < 12; c++) step(1'b1);
    for (int i = 0; i < 12; i++) check("order_all", 32'(gnt_log[i]), 32'(ord_all[i]));
    drain();

    // requester 0 drops after its only word; 2 takes over with no bubble
    do_reset();
    gnt_log.delete();
    prod_q[0].push_back(8'hA0);
    for (int v = 0; v < 3; v++) prod_q[2].push_back(DATA_WIDTH'(8'hC0 + v));
    for (int c = 0; c < 4; c++) step(1'b1);
    for (int i = 0; i < 4; i++) check("order_drop", 32'(gnt_log[i]), 32'(ord_drop[i]));
    drain();

    // full FIFO stalls requester 1 mid-burst; one read releases a grant
    do_reset();
    gnt_log.delete();
    prod_q[0].push_back(8'h11);
    for (int v = 0; v < 8; v++) prod_q[1].push_back(DATA_WIDTH'(8'h20 + v));
    for (int c = 0; c < 5; c++) step(1'b0);
    check("stall_state", 32'(diag_state), 32'd1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 8; i++) check("order_stall", 32'(gnt_log[i]), 32'(ord_stall[i]));
    drain();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_REQ; i++)
        if ($urandom_range(0, 99) < 20 && prod_q[i].size() < 4)
          prod_q[i].push_back(DATA_WIDTH'($urandom_range(0, 255)));
      step(1'($urandom_range(0, 1)));
    end
    drain();

    // reset while a write is registered mid-burst
    for (int v = 0; v < 3; v++) prod_q[1].push_back(DATA_WIDTH'(8'h50 + v));
    step(1'b0);
    step(1'b0);
    check("pre_rst_write", 32'(fifo_write), 32'd1);
    do_reset();
    for (int i = 0; i < N_REQ; i++) prod_q[i].delete();
    for (int i = 0; i < N_REQ; i++) prod_q[i].push_back(DATA_WIDTH'(8'h70 + i));
    gnt_log.delete();
    step(1'b0);
    check("post_rst_first_gnt", 32'(gnt_log[0]), 32'd0);
    drain();

    repeat (3) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
